// File: rtl/config_pkg.sv
// Shared configuration for the TLB access controller: SATP modes, privilege
// encodings, PTE bit positions and the controller state enum.
package config_pkg;

   localparam int unsigned SVMODE_BITS = 4;

   localparam logic [SVMODE_BITS-1:0] SATP_BARE = 4'd0;
   localparam logic [SVMODE_BITS-1:0] SATP_SV39 = 4'd8;
   localparam logic [SVMODE_BITS-1:0] SATP_SV48 = 4'd9;
   localparam logic [SVMODE_BITS-1:0] SATP_SV57 = 4'd10;

   localparam logic [1:0] PRIV_U = 2'd0;
   localparam logic [1:0] PRIV_S = 2'd1;
   localparam logic [1:0] PRIV_M = 2'd3;

   // PTEAccessBits layout: {N, PBMT[1:0], RSVD, D, A, G, U, X, W, R, V}
   localparam int unsigned PTE_V_BIT    = 0;
   localparam int unsigned PTE_R_BIT    = 1;
   localparam int unsigned PTE_W_BIT    = 2;
   localparam int unsigned PTE_X_BIT    = 3;
   localparam int unsigned PTE_U_BIT    = 4;
   localparam int unsigned PTE_G_BIT    = 5;
   localparam int unsigned PTE_A_BIT    = 6;
   localparam int unsigned PTE_D_BIT    = 7;
   localparam int unsigned PTE_RSVD_BIT = 8;
   localparam int unsigned PTE_PBMT_LSB = 9;
   localparam int unsigned PTE_PBMT_MSB = 10;
   localparam int unsigned PTE_N_BIT    = 11;

   localparam logic [1:0] PBMT_PMA  = 2'd0;
   localparam logic [1:0] PBMT_RSVD = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      CHECK,
      WALK,
      ADU,
      RESP
   } tlbac_state_e;

   // Translation applies when paging is enabled and the hart is not in M-mode.
   function automatic logic translate_on(input logic [SVMODE_BITS-1:0] satp_mode,
                                         input logic [1:0]             priv_mode);
      return (satp_mode != SATP_BARE) && (priv_mode != PRIV_M);
   endfunction

endpackage

// File: rtl/tlbpermcheck.sv
// Combinational permission check applied to a TLB hit: address canonicity,
// PTE validity, privilege, access type, PBMT/N/reserved and A/D state.
module tlbpermcheck
   import config_pkg::*;
#(
   parameter bit          ITLB = 1'b0,
   parameter int unsigned XLEN = 64
) (
   input  logic [XLEN-1:0]        vadr,
   input  logic [SVMODE_BITS-1:0] satp_mode,
   input  logic                   read_access,
   input  logic                   write_access,
   input  logic [3:0]             cmop,
   input  logic [1:0]             priv_mode,
   input  logic                   misaligned,
   input  logic                   status_sum,
   input  logic                   status_mxr,
   input  logic                   envcfg_pbmte,
   input  logic                   envcfg_adue,
   input  logic [11:0]            pte,
   output logic                   fault,
   output logic                   need_ad,
   output logic [1:0]             pbmt
);

   logic       upper_bits_fault;
   logic       pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d, pte_rsvd, pte_n;
   logic [1:0] pte_pbmt;
   logic       unused_g;

   assign pte_v    = pte[PTE_V_BIT];
   assign pte_r    = pte[PTE_R_BIT];
   assign pte_w    = pte[PTE_W_BIT];
   assign pte_x    = pte[PTE_X_BIT];
   assign pte_u    = pte[PTE_U_BIT];
   assign pte_a    = pte[PTE_A_BIT];
   assign pte_d    = pte[PTE_D_BIT];
   assign pte_rsvd = pte[PTE_RSVD_BIT];
   assign pte_n    = pte[PTE_N_BIT];
   assign pte_pbmt = pte[PTE_PBMT_MSB:PTE_PBMT_LSB];
   assign unused_g = pte[PTE_G_BIT];

   vm64check #(.XLEN(XLEN)) u_vm64check (
      .satp_mode        (satp_mode),
      .vadr             (vadr),
      .upper_bits_fault (upper_bits_fault)
   );

   // Combine every fault source; A/D need only faults when hardware update is off.
   always_comb begin
      logic priv_fault;
      logic access_fault;
      logic ext_fault;

      priv_fault   = 1'b0;
      access_fault = 1'b0;
      ext_fault    = 1'b0;

      if (priv_mode == PRIV_U) begin
         priv_fault = ~pte_u;
      end else if (priv_mode == PRIV_S) begin
         priv_fault = ITLB ? pte_u : (pte_u & ~status_sum);
      end

      if (ITLB) begin
         access_fault = ~pte_x;
      end else begin
         access_fault = ((read_access | (|cmop[2:0])) & ~pte_r & ~(status_mxr & pte_x))
                      | ((write_access | cmop[3]) & ~pte_w);
      end

      if (XLEN == 64) begin
         ext_fault = (pte_pbmt == PBMT_RSVD)
                   | ((pte_pbmt != PBMT_PMA) & ~envcfg_pbmte)
                   | pte_rsvd | pte_n;
      end

      need_ad = ~pte_a | (write_access & ~pte_d);

      fault = upper_bits_fault | misaligned | ~pte_v | (pte_w & ~pte_r)
            | priv_fault | access_fault | ext_fault | (need_ad & ~envcfg_adue);

      pbmt = (XLEN == 64) ? pte_pbmt : 2'b00;
   end

endmodule

// File: rtl/vm64check.sv
// Upper virtual-address check: bits above the active mode's VA width must be
// a sign extension of its top bit. Only meaningful on RV64.
module vm64check
   import config_pkg::*;
#(
   parameter int unsigned XLEN = 64
) (
   input  logic [SVMODE_BITS-1:0] satp_mode,
   input  logic [XLEN-1:0]        vadr,
   output logic                   upper_bits_fault
);

   if (XLEN == 64) begin : g_rv64
      logic unused_low;
      assign unused_low = ^vadr[37:0];

      // Upper bits must be all-zero or all-one from the mode's top VA bit up.
      always_comb begin
         upper_bits_fault = 1'b0;
         case (satp_mode)
            SATP_SV39: upper_bits_fault = ~((&vadr[63:38]) | ~(|vadr[63:38]));
            SATP_SV48: upper_bits_fault = ~((&vadr[63:47]) | ~(|vadr[63:47]));
            SATP_SV57: upper_bits_fault = ~((&vadr[63:56]) | ~(|vadr[63:56]));
            default:   upper_bits_fault = 1'b0;
         endcase
      end
   end else begin : g_rv32
      logic unused_in;
      assign unused_in        = ^{vadr, satp_mode};
      assign upper_bits_fault = 1'b0;
   end

endmodule

// File: rtl/tlbaccessctrl.sv
// Sequential TLB access controller: accepts one request, sequences lookup,
// page-table walks and A/D updates, and returns a single-cycle response.
module tlbaccessctrl
   import config_pkg::*;
#(
   parameter bit          ITLB      = 1'b0,
   parameter int unsigned XLEN      = 64,
   parameter int unsigned MAX_WALKS = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   ReqValid,
   output logic                   ReqReady,
   input  logic [XLEN-1:0]        VAdr,
   input  logic                   ReadAccess,
   input  logic                   WriteAccess,
   input  logic [3:0]             CMOpM,
   input  logic [1:0]             PrivMode,
   input  logic [SVMODE_BITS-1:0] SATP_MODE,
   input  logic                   STATUS_SUM,
   input  logic                   STATUS_MXR,
   input  logic                   ENVCFG_PBMTE,
   input  logic                   ENVCFG_ADUE,
   input  logic                   Misaligned,
   input  logic                   CAMHit,
   input  logic [11:0]            PTEAccessBits,
   output logic                   LookupEn,
   output logic                   WalkReq,
   input  logic                   WalkDone,
   input  logic                   WalkFault,
   output logic                   ADUReq,
   input  logic                   ADUAck,
   input  logic                   Flush,
   output logic                   RespValid,
   output logic                   RespFault,
   output logic                   RespError,
   output logic                   RespTranslated,
   output logic [1:0]             RespPBMT
);

   localparam int unsigned WCNT_W = (MAX_WALKS == 0) ? 1 : $clog2(MAX_WALKS + 1);

   tlbac_state_e state_q, state_d;
   logic [WCNT_W-1:0] walk_cnt_q;
   logic              walk_inc;
   logic              idle_q;
   logic              accept;

   logic [XLEN-1:0]        req_vadr_q;
   logic                   req_read_q, req_write_q, req_misaligned_q;
   logic [3:0]             req_cmop_q;
   logic [1:0]             req_priv_q;
   logic [SVMODE_BITS-1:0] req_satp_q;

   logic       resp_load;
   logic       resp_fault_d, resp_error_d, resp_translated_d;
   logic [1:0] resp_pbmt_d;
   logic       resp_fault_q, resp_error_q, resp_translated_q;
   logic [1:0] resp_pbmt_q;

   logic       chk_fault, chk_need_ad;
   logic [1:0] chk_pbmt;

   tlbpermcheck #(.ITLB(ITLB), .XLEN(XLEN)) u_permcheck (
      .vadr         (req_vadr_q),
      .satp_mode    (req_satp_q),
      .read_access  (req_read_q),
      .write_access (req_write_q),
      .cmop         (req_cmop_q),
      .priv_mode    (req_priv_q),
      .misaligned   (req_misaligned_q),
      .status_sum   (STATUS_SUM),
      .status_mxr   (STATUS_MXR),
      .envcfg_pbmte (ENVCFG_PBMTE),
      .envcfg_adue  (ENVCFG_ADUE),
      .pte          (PTEAccessBits),
      .fault        (chk_fault),
      .need_ad      (chk_need_ad),
      .pbmt         (chk_pbmt)
   );

   // ReqReady comes from a registered idle flag rather than state_q so that it
   // stays low while resetn is held, without feeding resetn into any data path.
   assign ReqReady  = idle_q & ~Flush;
   assign accept    = ReqValid & ReqReady;

   assign LookupEn  = (state_q == LOOKUP) & ~Flush;
   assign WalkReq   = (state_q == WALK)   & ~Flush;
   assign ADUReq    = (state_q == ADU)    & ~Flush;
   assign RespValid = (state_q == RESP)   & ~Flush;

   assign RespFault      = RespValid & resp_fault_q;
   assign RespError      = RespValid & resp_error_q;
   assign RespTranslated = RespValid & resp_translated_q;
   assign RespPBMT       = RespValid ? resp_pbmt_q : 2'b00;

   // Next-state and response-field selection; Flush overrides everything.
   always_comb begin
      state_d           = state_q;
      walk_inc          = 1'b0;
      resp_load         = 1'b0;
      resp_fault_d      = 1'b0;
      resp_error_d      = 1'b0;
      resp_translated_d = 1'b1;
      resp_pbmt_d       = 2'b00;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (translate_on(SATP_MODE, PrivMode)) begin
                  state_d = LOOKUP;
               end else begin
                  state_d           = RESP;
                  resp_load         = 1'b1;
                  resp_translated_d = 1'b0;
               end
            end
         end
         LOOKUP: state_d = CHECK;
         CHECK: begin
            if (!CAMHit) begin
               if (walk_cnt_q < WCNT_W'(MAX_WALKS)) begin
                  walk_inc = 1'b1;
                  state_d  = WALK;
               end else begin
                  state_d      = RESP;
                  resp_load    = 1'b1;
                  resp_error_d = 1'b1;
               end
            end else if (chk_fault) begin
               state_d      = RESP;
               resp_load    = 1'b1;
               resp_fault_d = 1'b1;
            end else if (chk_need_ad) begin
               state_d = ADU;
            end else begin
               state_d     = RESP;
               resp_load   = 1'b1;
               resp_pbmt_d = chk_pbmt;
            end
         end
         WALK: begin
            if (WalkDone) begin
               if (WalkFault) begin
                  state_d      = RESP;
                  resp_load    = 1'b1;
                  resp_fault_d = 1'b1;
               end else begin
                  state_d = LOOKUP;
               end
            end
         end
         ADU: begin
            if (ADUAck) state_d = LOOKUP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (Flush && (state_q != IDLE)) begin
         state_d   = IDLE;
         walk_inc  = 1'b0;
         resp_load = 1'b0;
      end
   end

   // State, idle flag and walk budget; the budget clears whenever IDLE is entered.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         idle_q     <= 1'b0;
         walk_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         idle_q  <= (state_d == IDLE);
         if (state_d == IDLE) begin
            walk_cnt_q <= '0;
         end else if (walk_inc) begin
            walk_cnt_q <= walk_cnt_q + WCNT_W'(1);
         end
      end
   end

   // Request register: captured on acceptance, held until the response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         req_vadr_q       <= '0;
         req_read_q       <= 1'b0;
         req_write_q      <= 1'b0;
         req_cmop_q       <= '0;
         req_priv_q       <= '0;
         req_satp_q       <= '0;
         req_misaligned_q <= 1'b0;
      end else if (accept) begin
         req_vadr_q       <= VAdr;
         req_read_q       <= ReadAccess;
         req_write_q      <= WriteAccess;
         req_cmop_q       <= CMOpM;
         req_priv_q       <= PrivMode;
         req_satp_q       <= SATP_MODE;
         req_misaligned_q <= Misaligned;
      end
   end

   // Response register: loaded on the transition into RESP.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_fault_q      <= 1'b0;
         resp_error_q      <= 1'b0;
         resp_translated_q <= 1'b0;
         resp_pbmt_q       <= '0;
      end else if (resp_load) begin
         resp_fault_q      <= resp_fault_d;
         resp_error_q      <= resp_error_d;
         resp_translated_q <= resp_translated_d;
         resp_pbmt_q       <= resp_pbmt_d;
      end
   end

endmodule

// File: tb/tb_tlbaccessctrl.sv
// Directed bench for tlbaccessctrl: a DTLB and an ITLB instance share stimulus.
module tb_tlbaccessctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        ReqValid, ReadAccess, WriteAccess, Misaligned, CAMHit;
   logic [63:0] VAdr;
   logic [3:0]  CMOpM, SATP_MODE;
   logic [1:0]  PrivMode;
   logic        STATUS_SUM, STATUS_MXR, ENVCFG_PBMTE, ENVCFG_ADUE;
   logic [11:0] PTEAccessBits;
   logic        WalkDone, WalkFault, ADUAck, Flush;

   logic       d_ReqReady, d_LookupEn, d_WalkReq, d_ADUReq, d_RespValid;
   logic       d_RespFault, d_RespError, d_RespTranslated;
   logic [1:0] d_RespPBMT;
   logic       i_ReqReady, i_LookupEn, i_WalkReq, i_ADUReq, i_RespValid;
   logic       i_RespFault, i_RespError, i_RespTranslated;
   logic [1:0] i_RespPBMT;

   int tests_run = 0;
   int tests_failed = 0;

   logic       ob_rdy0, ob_le1, ob_v2, ob_v3, ob_f3, ob_tr3, ob_err3, ob_adu3;
   logic       ob_i_v3, ob_i_f3;
   logic [1:0] ob_pb3;
   logic [2:0] ob_c4;

   always #5 clk = ~clk;

   tlbaccessctrl #(.ITLB(1'b0), .XLEN(64), .MAX_WALKS(2)) u_dtlb (
      .clk(clk), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(d_ReqReady),
      .VAdr(VAdr), .ReadAccess(ReadAccess), .WriteAccess(WriteAccess), .CMOpM(CMOpM),
      .PrivMode(PrivMode), .SATP_MODE(SATP_MODE), .STATUS_SUM(STATUS_SUM),
      .STATUS_MXR(STATUS_MXR), .ENVCFG_PBMTE(ENVCFG_PBMTE), .ENVCFG_ADUE(ENVCFG_ADUE),
      .Misaligned(Misaligned), .CAMHit(CAMHit), .PTEAccessBits(PTEAccessBits),
      .LookupEn(d_LookupEn), .WalkReq(d_WalkReq), .WalkDone(WalkDone), .WalkFault(WalkFault),
      .ADUReq(d_ADUReq), .ADUAck(ADUAck), .Flush(Flush), .RespValid(d_RespValid),
      .RespFault(d_RespFault), .RespError(d_RespError), .RespTranslated(d_RespTranslated),
      .RespPBMT(d_RespPBMT)
   );

   tlbaccessctrl #(.ITLB(1'b1), .XLEN(64), .MAX_WALKS(2)) u_itlb (
      .clk(clk), .resetn(resetn), .ReqValid(ReqValid), .ReqReady(i_ReqReady),
      .VAdr(VAdr), .ReadAccess(ReadAccess), .WriteAccess(WriteAccess), .CMOpM(CMOpM),
      .PrivMode(PrivMode), .SATP_MODE(SATP_MODE), .STATUS_SUM(STATUS_SUM),
      .STATUS_MXR(STATUS_MXR), .ENVCFG_PBMTE(ENVCFG_PBMTE), .ENVCFG_ADUE(ENVCFG_ADUE),
      .Misaligned(Misaligned), .CAMHit(CAMHit), .PTEAccessBits(PTEAccessBits),
      .LookupEn(i_LookupEn), .WalkReq(i_WalkReq), .WalkDone(WalkDone), .WalkFault(WalkFault),
      .ADUReq(i_ADUReq), .ADUAck(ADUAck), .Flush(Flush), .RespValid(i_RespValid),
      .RespFault(i_RespFault), .RespError(i_RespError), .RespTranslated(i_RespTranslated),
      .RespPBMT(i_RespPBMT)
   );

   // {N, PBMT, RSVD, D, A, G=0, U, X, W, R, V}
   function automatic logic [11:0] mkpte(input logic n, input logic [1:0] pbmt,
      input logic rsvd, input logic d, input logic a, input logic u,
      input logic x, input logic w, input logic r, input logic v);
      return {n, pbmt, rsvd, d, a, 1'b0, u, x, w, r, v};
   endfunction

   task set_defaults;
      ReqValid = 0; VAdr = 64'h0000_0000_1234_5000; ReadAccess = 1; WriteAccess = 0;
      CMOpM = 4'h0; PrivMode = 2'd1; SATP_MODE = 4'd8; STATUS_SUM = 0; STATUS_MXR = 0;
      ENVCFG_PBMTE = 1; ENVCFG_ADUE = 1; Misaligned = 0; CAMHit = 0; PTEAccessBits = '0;
      WalkDone = 0; WalkFault = 0; ADUAck = 0; Flush = 0;
   endtask

   task pulse_reset;
      @(negedge clk); resetn = 0; #1; resetn = 1;
   endtask

   // Drives a request that hits in cycle 2 with PTE p and records outputs per cycle.
   task run_hit(input logic [11:0] p);
      pulse_reset();
      @(negedge clk); ReqValid = 1; #1 ob_rdy0 = d_ReqReady;
      @(negedge clk); ReqValid = 0; #1 ob_le1 = d_LookupEn;
      @(negedge clk); CAMHit = 1; PTEAccessBits = p; #1 ob_v2 = d_RespValid;
      @(negedge clk); CAMHit = 0;
      #1 begin
         ob_v3 = d_RespValid; ob_f3 = d_RespFault; ob_pb3 = d_RespPBMT; ob_tr3 = d_RespTranslated;
         ob_err3 = d_RespError; ob_adu3 = d_ADUReq; ob_i_v3 = i_RespValid; ob_i_f3 = i_RespFault;
      end
      @(negedge clk); #1 ob_c4 = {d_RespValid, d_RespPBMT};
   endtask

   task test_reset;
      @(negedge clk); resetn = 0; #1;
      tests_run++; if ({d_ReqReady, d_LookupEn, d_WalkReq, d_ADUReq, d_RespValid, d_RespFault, d_RespError, d_RespTranslated, d_RespPBMT} !== 10'h0) begin tests_failed++; $display("FAIL reset_d_outputs got %0h want 0", {d_ReqReady, d_LookupEn, d_WalkReq, d_ADUReq, d_RespValid, d_RespFault, d_RespError, d_RespTranslated, d_RespPBMT}); end
      tests_run++; if ({i_ReqReady, i_LookupEn, i_WalkReq, i_ADUReq, i_RespValid, i_RespPBMT} !== 7'h0) begin tests_failed++; $display("FAIL reset_i_outputs got %0h want 0", {i_ReqReady, i_LookupEn, i_WalkReq, i_ADUReq, i_RespValid, i_RespPBMT}); end
      @(negedge clk); resetn = 1;
      @(negedge clk); #1;
      tests_run++; if (d_ReqReady !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", d_ReqReady); end
   endtask

   task test_hit_pbmt;
      set_defaults();
      run_hit(mkpte(0, 2'd1, 0, 0, 1, 0, 0, 0, 1, 1));
      tests_run++; if (ob_rdy0 !== 1'b1) begin tests_failed++; $display("FAIL hit_ready_c0 got %b want 1", ob_rdy0); end
      tests_run++; if (ob_le1 !== 1'b1) begin tests_failed++; $display("FAIL hit_lookupen_c1 got %b want 1", ob_le1); end
      tests_run++; if (ob_v2 !== 1'b0) begin tests_failed++; $display("FAIL hit_valid_c2 got %b want 0", ob_v2); end
      tests_run++; if ({ob_v3, ob_f3, ob_err3, ob_tr3, ob_pb3} !== 6'b100101) begin tests_failed++; $display("FAIL hit_resp_c3 got %b want 100101", {ob_v3, ob_f3, ob_err3, ob_tr3, ob_pb3}); end
      tests_run++; if (ob_c4 !== 3'b000) begin tests_failed++; $display("FAIL hit_resp_c4 got %b want 000", ob_c4); end
      ENVCFG_PBMTE = 0;
      run_hit(mkpte(0, 2'd1, 0, 0, 1, 0, 0, 0, 1, 1));
      tests_run++; if ({ob_v3, ob_f3, ob_pb3} !== 4'b1100) begin tests_failed++; $display("FAIL pbmte_off got %b want 1100", {ob_v3, ob_f3, ob_pb3}); end
      ENVCFG_PBMTE = 1;
      run_hit(mkpte(0, 2'd3, 0, 0, 1, 0, 0, 0, 1, 1));
      tests_run++; if (ob_f3 !== 1'b1) begin tests_failed++; $display("FAIL pbmt3 got %b want 1", ob_f3); end
      VAdr = 64'h0000_0040_0000_0000;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 1));
      tests_run++; if (ob_f3 !== 1'b1) begin tests_failed++; $display("FAIL noncanonical got %b want 1", ob_f3); end
      VAdr = 64'hFFFF_FFC0_0000_1000;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 1));
      tests_run++; if ({ob_v3, ob_f3} !== 2'b10) begin tests_failed++; $display("FAIL canonical_high got %b want 10", {ob_v3, ob_f3}); end
      VAdr = 64'h0000_0000_1234_5000; Misaligned = 1;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 1));
      tests_run++; if (ob_f3 !== 1'b1) begin tests_failed++; $display("FAIL misaligned got %b want 1", ob_f3); end
   endtask

   task test_perm;
      set_defaults(); PrivMode = 2'd0; ReadAccess = 0;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 1));
      tests_run++; if ({ob_i_v3, ob_i_f3} !== 2'b11) begin tests_failed++; $display("FAIL itlb_u_on_s_page got %b want 11", {ob_i_v3, ob_i_f3}); end
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 1, 1, 0, 0, 1));
      tests_run++; if ({ob_i_v3, ob_i_f3} !== 2'b10) begin tests_failed++; $display("FAIL itlb_u_on_u_page got %b want 10", {ob_i_v3, ob_i_f3}); end
      PrivMode = 2'd1; ReadAccess = 1;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 1, 0, 0, 1, 1));
      tests_run++; if (ob_f3 !== 1'b1) begin tests_failed++; $display("FAIL sum0_upage got %b want 1", ob_f3); end
      STATUS_SUM = 1;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 1, 0, 0, 1, 1));
      tests_run++; if ({ob_v3, ob_f3} !== 2'b10) begin tests_failed++; $display("FAIL sum1_upage got %b want 10", {ob_v3, ob_f3}); end
      STATUS_SUM = 0; STATUS_MXR = 1;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 1));
      tests_run++; if ({ob_v3, ob_f3} !== 2'b10) begin tests_failed++; $display("FAIL mxr1_xonly got %b want 10", {ob_v3, ob_f3}); end
      STATUS_MXR = 0;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 0, 1, 0, 0, 1));
      tests_run++; if (ob_f3 !== 1'b1) begin tests_failed++; $display("FAIL mxr0_xonly got %b want 1", ob_f3); end
      ReadAccess = 0; CMOpM = 4'b1000;
      run_hit(mkpte(0, 2'd0, 0, 1, 1, 0, 0, 0, 1, 1));
      tests_run++; if (ob_f3 !== 1'b1) begin tests_failed++; $display("FAIL cbo_zero_readonly got %b want 1", ob_f3); end
   endtask

   task test_miss_refill;
      set_defaults(); pulse_reset();
      @(negedge clk); ReqValid = 1;
      @(negedge clk); ReqValid = 0;
      @(negedge clk); CAMHit = 0; #1;
      tests_run++; if (d_WalkReq !== 1'b0) begin tests_failed++; $display("FAIL miss_walkreq_check got %b want 0", d_WalkReq); end
      @(negedge clk); #1;
      tests_run++; if (d_WalkReq !== 1'b1) begin tests_failed++; $display("FAIL miss_walkreq_rise got %b want 1", d_WalkReq); end
      @(negedge clk); #1;
      tests_run++; if (d_WalkReq !== 1'b1) begin tests_failed++; $display("FAIL miss_walkreq_held got %b want 1", d_WalkReq); end
      WalkDone = 1;
      @(negedge clk); WalkDone = 0; #1;
      tests_run++; if ({d_LookupEn, d_WalkReq} !== 2'b10) begin tests_failed++; $display("FAIL miss_relookup got %b want 10", {d_LookupEn, d_WalkReq}); end
      @(negedge clk); CAMHit = 1; PTEAccessBits = mkpte(0, 2'd0, 0, 0, 1, 0, 0, 0, 1, 1);
      @(negedge clk); CAMHit = 0; #1;
      tests_run++; if ({d_RespValid, d_RespFault, d_RespError, d_WalkReq} !== 4'b1000) begin tests_failed++; $display("FAIL miss_resp got %b want 1000", {d_RespValid, d_RespFault, d_RespError, d_WalkReq}); end
   endtask

   task test_walk_budget;
      int walks, resp_cyc;
      logic err, flt;
      set_defaults(); pulse_reset();
      walks = 0; resp_cyc = 0; err = 0; flt = 0;
      @(negedge clk); ReqValid = 1;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk); ReqValid = 0; CAMHit = 0;
         WalkDone = d_WalkReq;
         if (d_WalkReq) walks++;
         #1;
         if (d_RespValid) begin
            resp_cyc = cyc; err = d_RespError; flt = d_RespFault;
            break;
         end
      end
      WalkDone = 0;
      tests_run++; if (walks !== 2) begin tests_failed++; $display("FAIL budget_walks got %0d want 2", walks); end
      tests_run++; if (resp_cyc !== 9) begin tests_failed++; $display("FAIL budget_resp_cycle got %0d want 9", resp_cyc); end
      tests_run++; if ({err, flt} !== 2'b10) begin tests_failed++; $display("FAIL budget_error got %b want 10", {err, flt}); end
      // Next request must get a fresh walk budget.
      @(negedge clk); ReqValid = 1; #1;
      tests_run++; if (d_ReqReady !== 1'b1) begin tests_failed++; $display("FAIL budget_ready got %b want 1", d_ReqReady); end
      @(negedge clk); ReqValid = 0;
      @(negedge clk);
      @(negedge clk); #1;
      tests_run++; if (d_WalkReq !== 1'b1) begin tests_failed++; $display("FAIL budget_cleared got %b want 1", d_WalkReq); end
   endtask

   task test_adu;
      set_defaults(); ReadAccess = 0; WriteAccess = 1; pulse_reset();
      @(negedge clk); ReqValid = 1;
      @(negedge clk); ReqValid = 0;
      @(negedge clk); CAMHit = 1; PTEAccessBits = mkpte(0, 2'd0, 0, 0, 1, 0, 0, 1, 1, 1);
      @(negedge clk); CAMHit = 0; #1;
      tests_run++; if ({d_ADUReq, d_RespValid} !== 2'b10) begin tests_failed++; $display("FAIL adu_req got %b want 10", {d_ADUReq, d_RespValid}); end
      @(negedge clk); #1;
      tests_run++; if (d_ADUReq !== 1'b1) begin tests_failed++; $display("FAIL adu_held got %b want 1", d_ADUReq); end
      ADUAck = 1;
      @(negedge clk); ADUAck = 0; #1;
      tests_run++; if ({d_LookupEn, d_ADUReq} !== 2'b10) begin tests_failed++; $display("FAIL adu_relookup got %b want 10", {d_LookupEn, d_ADUReq}); end
      @(negedge clk); CAMHit = 1; PTEAccessBits = mkpte(0, 2'd0, 0, 1, 1, 0, 0, 1, 1, 1);
      @(negedge clk); CAMHit = 0; #1;
      tests_run++; if ({d_RespValid, d_RespFault} !== 2'b10) begin tests_failed++; $display("FAIL adu_resp got %b want 10", {d_RespValid, d_RespFault}); end
      ENVCFG_ADUE = 0;
      run_hit(mkpte(0, 2'd0, 0, 0, 1, 0, 0, 1, 1, 1));
      tests_run++; if ({ob_v3, ob_f3, ob_adu3} !== 3'b110) begin tests_failed++; $display("FAIL adue0_fault got %b want 110", {ob_v3, ob_f3, ob_adu3}); end
   endtask

   task test_flush;
      set_defaults(); pulse_reset();
      @(negedge clk); ReqValid = 1;
      @(negedge clk); ReqValid = 0;
      @(negedge clk); CAMHit = 0;
      @(negedge clk); #1;
      tests_run++; if (d_WalkReq !== 1'b1) begin tests_failed++; $display("FAIL flush_walk_entered got %b want 1", d_WalkReq); end
      @(negedge clk); WalkDone = 1; Flush = 1; #1;
      tests_run++; if (d_WalkReq !== 1'b0) begin tests_failed++; $display("FAIL flush_walkreq_drop got %b want 0", d_WalkReq); end
      @(negedge clk); WalkDone = 0; Flush = 0; #1;
      tests_run++; if ({d_ReqReady, d_LookupEn, d_WalkReq, d_RespValid} !== 4'b1000) begin tests_failed++; $display("FAIL flush_walk_idle got %b want 1000", {d_ReqReady, d_LookupEn, d_WalkReq, d_RespValid}); end
      @(negedge clk); #1;
      tests_run++; if (d_RespValid !== 1'b0) begin tests_failed++; $display("FAIL flush_no_resp got %b want 0", d_RespValid); end
      // Flush coincident with ADUAck.
      ReadAccess = 0; WriteAccess = 1; pulse_reset();
      @(negedge clk); ReqValid = 1;
      @(negedge clk); ReqValid = 0;
      @(negedge clk); CAMHit = 1; PTEAccessBits = mkpte(0, 2'd0, 0, 0, 1, 0, 0, 1, 1, 1);
      @(negedge clk); CAMHit = 0; Flush = 1; ADUAck = 1; #1;
      tests_run++; if (d_ADUReq !== 1'b0) begin tests_failed++; $display("FAIL flush_adureq_drop got %b want 0", d_ADUReq); end
      @(negedge clk); Flush = 0; ADUAck = 0; #1;
      tests_run++; if ({d_ReqReady, d_LookupEn, d_ADUReq} !== 3'b100) begin tests_failed++; $display("FAIL flush_adu_idle got %b want 100", {d_ReqReady, d_LookupEn, d_ADUReq}); end
   endtask

   task test_reset_in_adu;
      set_defaults(); ReadAccess = 0; WriteAccess = 1; pulse_reset();
      @(negedge clk); ReqValid = 1;
      @(negedge clk); ReqValid = 0;
      @(negedge clk); CAMHit = 1; PTEAccessBits = mkpte(0, 2'd0, 0, 0, 1, 0, 0, 1, 1, 1);
      @(negedge clk); CAMHit = 0; #1;
      tests_run++; if (d_ADUReq !== 1'b1) begin tests_failed++; $display("FAIL rstadu_in_adu got %b want 1", d_ADUReq); end
      #1 resetn = 0; #1;
      tests_run++; if ({d_ReqReady, d_LookupEn, d_WalkReq, d_ADUReq, d_RespValid, d_RespFault, d_RespError, d_RespTranslated, d_RespPBMT} !== 10'h0) begin tests_failed++; $display("FAIL rstadu_outputs got %0h want 0", {d_ReqReady, d_LookupEn, d_WalkReq, d_ADUReq, d_RespValid, d_RespFault, d_RespError, d_RespTranslated, d_RespPBMT}); end
      @(negedge clk); resetn = 1;
      @(negedge clk); #1;
      tests_run++; if ({d_ReqReady, d_ADUReq} !== 2'b10) begin tests_failed++; $display("FAIL rstadu_recover got %b want 10", {d_ReqReady, d_ADUReq}); end
   endtask

   task test_bypass;
      set_defaults(); SATP_MODE = 4'd0; PTEAccessBits = mkpte(0, 2'd1, 0, 1, 1, 0, 0, 0, 1, 1);
      pulse_reset();
      @(negedge clk); ReqValid = 1;
      @(negedge clk); ReqValid = 0; #1;
      tests_run++; if ({d_LookupEn, d_RespValid, d_RespTranslated, d_RespFault, d_RespPBMT} !== 6'b010000) begin tests_failed++; $display("FAIL bare_resp got %b want 010000", {d_LookupEn, d_RespValid, d_RespTranslated, d_RespFault, d_RespPBMT}); end
      @(negedge clk); #1;
      tests_run++; if (d_RespValid !== 1'b0) begin tests_failed++; $display("FAIL bare_resp_drop got %b want 0", d_RespValid); end
      SATP_MODE = 4'd8; PrivMode = 2'd3;
      @(negedge clk); ReqValid = 1;
      @(negedge clk); ReqValid = 0; #1;
      tests_run++; if ({d_LookupEn, d_RespValid, d_RespTranslated} !== 3'b010) begin tests_failed++; $display("FAIL mmode_resp got %b want 010", {d_LookupEn, d_RespValid, d_RespTranslated}); end
   endtask

   task test_back_to_back;
      set_defaults(); SATP_MODE = 4'd0; pulse_reset();
      @(negedge clk); ReqValid = 1;
      @(negedge clk); #1;
      tests_run++; if ({d_RespValid, d_ReqReady} !== 2'b10) begin tests_failed++; $display("FAIL b2b_first got %b want 10", {d_RespValid, d_ReqReady}); end
      @(negedge clk); #1;
      tests_run++; if ({d_RespValid, d_ReqReady} !== 2'b01) begin tests_failed++; $display("FAIL b2b_accept2 got %b want 01", {d_RespValid, d_ReqReady}); end
      @(negedge clk); ReqValid = 0; #1;
      tests_run++; if (d_RespValid !== 1'b1) begin tests_failed++; $display("FAIL b2b_second got %b want 1", d_RespValid); end
   endtask

   initial begin
      set_defaults();
      test_reset();
      test_hit_pbmt();
      test_perm();
      test_miss_refill();
      test_walk_budget();
      test_adu();
      test_flush();
      test_reset_in_adu();
      test_bypass();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
